// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the I2C target
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_POS = 0;

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - user-side byte handshake of the I2C target
interface i2c_slave_if;

  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;

  modport slave (
    input  tx_data,
    output rx_data,
    output rx_valid,
    output tx_req,
    output busy
  );

  modport master (
    output tx_data,
    input  rx_data,
    input  rx_valid,
    input  tx_req,
    input  busy
  );

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers and registered bus events
module i2c_line_sync (
  input  logic clk,
  input  logic areset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  // [0],[1] synchronize, [2] is the previous value for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      scl_rise_q <= scl_q[1] & ~scl_q[2];
      scl_fall_q <= ~scl_q[1] & scl_q[2];
      start_q    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  assign sda_o       = sda_q[2];
  assign scl_rise_o  = scl_rise_q;
  assign scl_fall_o  = scl_fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: address match, byte write/read, open-drain SDA
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave usr
);

  logic sda_in;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_sync (
    .clk         (clk),
    .areset      (areset),
    .scl_i       (scl),
    .sda_i       (sda),
    .sda_o       (sda_in),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      armed_q    <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  // armed_q: a full byte was shifted in (or a read ACK was seen) and the next scl_fall acts on it
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (start_det || stop_det) begin
      state_d = start_det ? ST_ADDR : ST_IDLE;
      cnt_d   = 3'd0;
      armed_d = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: oe_d = 1'b0;

        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_in};
            cnt_d   = cnt_q + 3'd1;
            armed_d = (cnt_q == 3'd7);
          end else if (scl_fall && armed_q) begin
            armed_d = 1'b0;
            if (state_q == ST_WR_DATA) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              oe_d       = 1'b1;
              state_d    = ST_WR_ACK;
            end else if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d    = shift_q[RW_POS];
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_ADDR_ACK, ST_RD_ACK: begin
          if (state_q == ST_RD_ACK && scl_rise) begin
            if (sda_in == NACK) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              oe_d    = 1'b0;
            end else begin
              armed_d = 1'b1;
            end
          end else if (scl_fall && (state_q == ST_ADDR_ACK || armed_q)) begin
            armed_d = 1'b0;
            cnt_d   = 3'd0;
            if (state_q == ST_ADDR_ACK && rw_q == 1'b0) begin
              oe_d    = 1'b0;
              state_d = ST_WR_DATA;
            end else begin
              shift_d  = usr.tx_data;
              tx_req_d = 1'b1;
              oe_d     = ~usr.tx_data[7];
              state_d  = ST_RD_DATA;
            end
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = ST_WR_DATA;
          end
        end

        ST_RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = ST_RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign sda = oe_q ? 1'b0 : 1'bz;

  assign usr.rx_data  = rx_data_q;
  assign usr.rx_valid = rx_valid_q;
  assign usr.tx_req   = tx_req_q;
  assign usr.busy     = busy_q;

endmodule
